// File: rtl/alu_vec_seq.sv
// Multi-beat vector ALU: accepts a wide operation and processes LANES elements per cycle.
module alu_vec_seq #(
    parameter int unsigned VEC_BITS = 256,
    parameter int unsigned ELEM     = 16,
    parameter int unsigned LANES    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [VEC_BITS-1:0]        vectorA,
    input  logic [VEC_BITS-1:0]        vectorB,
    input  logic [2:0]                 opcode,
    input  logic                       sat,
    input  logic [VEC_BITS/ELEM-1:0]   mask,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [VEC_BITS-1:0]        result,
    output logic                       ovf,
    output logic                       busy
);

    localparam int unsigned N_ELEM = VEC_BITS / ELEM;
    localparam int unsigned BEATS  = N_ELEM / LANES;
    localparam int unsigned CW     = $clog2(BEATS + 1);
    localparam int unsigned SHW    = $clog2(ELEM);
    localparam int unsigned BW     = LANES * ELEM;

    localparam logic [ELEM-1:0] SMAX = {1'b0, {(ELEM-1){1'b1}}};
    localparam logic [ELEM-1:0] SMIN = {1'b1, {(ELEM-1){1'b0}}};

    // Reject geometries that do not split into whole elements and whole beats.
    if ((N_ELEM * ELEM != VEC_BITS) || (BEATS * LANES != N_ELEM) || (BEATS < 1)) begin : g_param_check
        $error("alu_vec_seq: VEC_BITS/ELEM/LANES must divide exactly with at least one beat");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       k_q;
    logic [CW-1:0]       beat;
    logic [VEC_BITS-1:0] a_q, b_q;
    logic [2:0]          op_q;
    logic                sat_q;
    logic [N_ELEM-1:0]   mask_q;
    logic [BW-1:0]       beat_a, beat_b, beat_res;
    logic [LANES-1:0]    beat_mask;
    logic                beat_ovf;
    logic [ELEM:0]       lane_out;

    // One element operation; returns {overflow, value}.
    function automatic logic [ELEM:0] alu_elem(input logic [ELEM-1:0] a, input logic [ELEM-1:0] b,
                                               input logic [2:0] op, input logic s);
        logic [ELEM:0]     wide;
        logic [2*ELEM-1:0] prod;
        logic [ELEM-1:0]   r;
        logic              v;
        logic [SHW-1:0]    sh;
        wide = '0;
        prod = '0;
        r    = '0;
        v    = 1'b0;
        sh   = b[SHW-1:0];
        case (op)
            3'b000, 3'b001: begin
                wide = (op == 3'b000) ? ({a[ELEM-1], a} + {b[ELEM-1], b})
                                      : ({a[ELEM-1], a} - {b[ELEM-1], b});
                v = wide[ELEM] ^ wide[ELEM-1];
                r = (v && s) ? (wide[ELEM] ? SMIN : SMAX) : wide[ELEM-1:0];
            end
            3'b010: begin
                // Low 2*ELEM bits of the sign-extended product equal the signed product.
                prod = {{ELEM{a[ELEM-1]}}, a} * {{ELEM{b[ELEM-1]}}, b};
                r    = prod[ELEM-1:0];
                v    = (prod[2*ELEM-1:ELEM] != {ELEM{prod[ELEM-1]}});
            end
            3'b011:  r = a & b;
            3'b100:  r = a | b;
            3'b101:  r = a ^ b;
            3'b110:  r = a << sh;
            default: r = ELEM'($signed(a) >>> sh);
        endcase
        return {v, r};
    endfunction

    // Current beat slice; clamped so the index stays in range once all beats are done.
    assign beat      = (k_q < CW'(BEATS)) ? k_q : '0;
    assign beat_a    = a_q[beat*BW +: BW];
    assign beat_b    = b_q[beat*BW +: BW];
    assign beat_mask = mask_q[beat*LANES +: LANES];

    // Lane datapath: masked-out elements pass A through and never flag overflow.
    always_comb begin
        beat_res = '0;
        beat_ovf = 1'b0;
        lane_out = '0;
        for (int j = 0; j < LANES; j++) begin
            lane_out = alu_elem(beat_a[j*ELEM +: ELEM], beat_b[j*ELEM +: ELEM], op_q, sat_q);
            if (beat_mask[j]) begin
                beat_res[j*ELEM +: ELEM] = lane_out[ELEM-1:0];
                beat_ovf                 = beat_ovf | lane_out[ELEM];
            end else begin
                beat_res[j*ELEM +: ELEM] = beat_a[j*ELEM +: ELEM];
            end
        end
    end

    // Next-state logic; RUN lingers one cycle after the last beat before DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (k_q == CW'(BEATS)) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
            busy      <= (state_d != IDLE);
        end
    end

    // Operand capture, beat counter, result and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            sat_q  <= 1'b0;
            mask_q <= '0;
            k_q    <= '0;
            result <= '0;
            ovf    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= vectorA;
                        b_q    <= vectorB;
                        op_q   <= opcode;
                        sat_q  <= sat;
                        mask_q <= mask;
                        k_q    <= '0;
                        ovf    <= 1'b0;
                    end
                end
                RUN: begin
                    if (k_q < CW'(BEATS)) begin
                        result[beat*BW +: BW] <= beat_res;
                        ovf                   <= ovf | beat_ovf;
                        k_q                   <= k_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_vec_seq.sv
// Scoreboard bench for alu_vec_seq with a plain-arithmetic reference model.
module tb_alu_vec_seq;

    localparam int V = 256;
    localparam int E = 16;
    localparam int N = 16;

    typedef struct {
        logic [V-1:0] r;
        logic         o;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         sat = 1'b0;
    logic [V-1:0] vectorA = '0;
    logic [V-1:0] vectorB = '0;
    logic [2:0]   opcode = '0;
    logic [N-1:0] mask = '0;
    logic         in_ready, out_valid, ovf, busy;
    logic [V-1:0] result;

    logic         in_valid16 = 1'b0, in_valid1 = 1'b0, alt_ready = 1'b1;
    logic         ir16, ov16, ovf16, busy16, ir1, ov1, ovf1, busy1;
    logic [V-1:0] res16, res1;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    exp_t scb[$];
    exp_t mon_e;

    alu_vec_seq #(.VEC_BITS(V), .ELEM(E), .LANES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .vectorA(vectorA), .vectorB(vectorB), .opcode(opcode), .sat(sat), .mask(mask),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .ovf(ovf), .busy(busy));

    alu_vec_seq #(.VEC_BITS(V), .ELEM(E), .LANES(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(ir16),
        .vectorA(vectorA), .vectorB(vectorB), .opcode(opcode), .sat(sat), .mask(mask),
        .out_valid(ov16), .out_ready(alt_ready), .result(res16), .ovf(ovf16), .busy(busy16));

    alu_vec_seq #(.VEC_BITS(V), .ELEM(E), .LANES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(ir1),
        .vectorA(vectorA), .vectorB(vectorB), .opcode(opcode), .sat(sat), .mask(mask),
        .out_valid(ov1), .out_ready(alt_ready), .result(res1), .ovf(ovf1), .busy(busy1));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [V-1:0] act, input logic [V-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Reference: each element computed as a signed integer, then range-checked and wrapped.
    function automatic exp_t model(input logic [V-1:0] a, input logic [V-1:0] b, input logic [2:0] op,
                                   input logic s, input logic [N-1:0] m);
        exp_t        e;
        longint      sa, sb2, v;
        logic [E-1:0] ae, be, r;
        int          sh;
        bit          o;
        e.r = '0;
        e.o = 1'b0;
        for (int i = 0; i < N; i++) begin
            ae  = a[i*E +: E];
            be  = b[i*E +: E];
            sa  = longint'(ae);
            sb2 = longint'(be);
            if (sa > 32767) sa = sa - 65536;
            if (sb2 > 32767) sb2 = sb2 - 65536;
            sh = int'(be) % E;
            o  = 1'b0;
            case (op)
                3'd0:    v = sa + sb2;
                3'd1:    v = sa - sb2;
                3'd2:    v = sa * sb2;
                3'd3:    v = longint'(ae & be);
                3'd4:    v = longint'(ae | be);
                3'd5:    v = longint'(ae ^ be);
                3'd6:    v = longint'(ae) * (longint'(1) << sh);
                default: v = sa >>> sh;
            endcase
            if (op <= 3'd2) begin
                o = (v > 32767) || (v < -32768);
                if (s && op < 3'd2 && o) v = (v > 0) ? 32767 : -32768;
            end
            r = 16'(v);
            e.r[i*E +: E] = m[i] ? r : ae;
            if (m[i]) e.o = e.o | o;
        end
        return e;
    endfunction

    function automatic logic [V-1:0] rep(input logic [E-1:0] x);
        logic [V-1:0] r;
        for (int i = 0; i < N; i++) r[i*E +: E] = x;
        return r;
    endfunction

    function automatic logic [V-1:0] rand_vec();
        logic [V-1:0] r;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 3))
                0:       r[i*E +: E] = 16'h7FFF;
                1:       r[i*E +: E] = 16'h8000;
                default: r[i*E +: E] = 16'($urandom);
            endcase
        end
        return r;
    endfunction

    // Monitor: compare every accepted output against the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (scb.size() == 0) begin
                chk("sb_underflow", V'(scb.size()), V'(1));
            end else begin
                mon_e = scb.pop_front();
                chk("result", result, mon_e.r);
                chk("ovf", V'(ovf), V'(mon_e.o));
            end
        end
    end

    task automatic issue(input logic [V-1:0] a, input logic [V-1:0] b, input logic [2:0] op,
                         input logic s, input logic [N-1:0] m, input bit rnd);
        int n = 0;
        while (!in_ready && n < 300) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("accept_timeout", V'(in_ready), V'(1));
        vectorA  = a;
        vectorB  = b;
        opcode   = op;
        sat      = s;
        mask     = m;
        in_valid = 1'b1;
        scb.push_back(model(a, b, op, s, m));
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("valid_timeout", V'(out_valid), V'(1));
    endtask

    task automatic drain(input bit rnd);
        int n = 0;
        while (scb.size() != 0 && n < 300) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        chk("drain", V'(scb.size()), V'(0));
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_alt(input bit one, input int beats);
        int   n = 0;
        int   t;
        exp_t e;
        vectorA = rep(16'h0001);
        vectorB = rep(16'h0002);
        opcode  = 3'd0;
        sat     = 1'b0;
        mask    = '1;
        e = model(vectorA, vectorB, 3'd0, 1'b0, mask);
        if (one) in_valid1 = 1'b1; else in_valid16 = 1'b1;
        @(posedge clk); #1;
        t = cyc;
        in_valid1  = 1'b0;
        in_valid16 = 1'b0;
        while (!(one ? ov1 : ov16) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk(one ? "lat_lanes1" : "lat_lanes16", V'(cyc - t), V'(beats + 1));
        chk(one ? "res_lanes1" : "res_lanes16", one ? res1 : res16, e.r);
        chk(one ? "ovf_lanes1" : "ovf_lanes16", V'(one ? ovf1 : ovf16), V'(e.o));
        @(posedge clk); #1;
        chk(one ? "idle_lanes1" : "idle_lanes16",
            V'(one ? {ir1, busy1} : {ir16, busy16}), V'(2'b10));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Asynchronous reset assertion and reset values.
        #1 rst_n = 1'b0;
        #2;
        chk("rst_state", V'({in_ready, out_valid, busy, ovf}), V'(4'b1000));
        chk("rst_result", result, '0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic add with latency check.
        issue(rep(16'h0001), rep(16'h0002), 3'd0, 1'b0, '1, 1'b0);
        chk("busy_run", V'({busy, in_ready}), V'(2'b10));
        wait_valid();
        chk("latency", V'(cyc - acc_cyc), V'(5));
        drain(1'b0);

        // Saturation, wrap, masking and the other directed corner cases.
        issue(rep(16'h7FFF), rep(16'h0001), 3'd0, 1'b1, '1, 1'b0);
        drain(1'b0);
        issue(rep(16'h7FFF), rep(16'h0001), 3'd0, 1'b0, '1, 1'b0);
        drain(1'b0);
        issue(rep(16'h8000), rep(16'h0001), 3'd1, 1'b1, 16'h00FF, 1'b0);
        drain(1'b0);
        issue(rep(16'h8000), rep(16'h0001), 3'd1, 1'b1, 16'h0000, 1'b0);
        drain(1'b0);
        issue(rep(16'hF000), rep(16'h0004), 3'd7, 1'b0, '1, 1'b0);
        drain(1'b0);
        issue(rep(16'h0100), rep(16'h0100), 3'd2, 1'b0, '1, 1'b0);
        drain(1'b0);

        // Backpressure in DONE: output held, further requests refused.
        out_ready = 1'b0;
        issue(rep(16'h1234), rep(16'h0F0F), 3'd5, 1'b0, 16'hA5A5, 1'b0);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            vectorA  = rand_vec();
            @(negedge clk);
            chk("hold_result", result, scb[0].r);
            chk("hold_flags", V'({in_ready, out_valid}), V'(2'b01));
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_idle", V'({in_ready, out_valid, busy}), V'(3'b100));
        issue(rep(16'h0003), rep(16'h0004), 3'd0, 1'b0, '1, 1'b0);
        drain(1'b0);

        // Reset during beat 2 clears outputs without a clock edge.
        issue(rep(16'h0005), rep(16'h0006), 3'd0, 1'b0, '1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_state", V'({in_ready, out_valid, busy, ovf}), V'(4'b1000));
        chk("midrst_result", result, '0);
        scb.delete();
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        issue(rep(16'h0001), rep(16'h0002), 3'd0, 1'b0, '1, 1'b0);
        wait_valid();
        chk("latency_after_rst", V'(cyc - acc_cyc), V'(5));
        drain(1'b0);

        // Randomised operations with random backpressure.
        for (int i = 0; i < 40; i++) begin
            issue(rand_vec(), rand_vec(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom), 1'b1);
        end
        drain(1'b1);

        // Same first operation on the wide and narrow lane configurations.
        run_alt(1'b0, 1);
        run_alt(1'b1, 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
